// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo FIFO block.
package uart_echo_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

   localparam int unsigned DEFAULT_TERM_WORD = 32'h0000_000D;
   localparam int          STATS_WIDTH       = 16;

endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// Synchronous FIFO with combinational head read and an occupancy counter
// carrying one extra bit so a full FIFO is distinguishable from an empty one.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int LW = AW + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_pop_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [LW-1:0]         o_level
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         count_q, count_d;
   logic                  do_push;
   logic                  do_pop;

   assign o_full     = (count_q == LW'(FIFO_DEPTH));
   assign o_empty    = (count_q == '0);
   assign o_level    = count_q;
   assign o_pop_data = mem_q[rd_ptr_q];
   assign do_push    = i_push && !o_full;
   assign do_pop     = i_pop && !o_empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = i_push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo engine: queues received words and replays them to the
// transmitter. Optional statistics counters are enabled by UART_ECHO_STATS_EN.
module uart_echo_fifo
   import uart_echo_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          FIFO_DEPTH = 16,
   parameter int          LINE_MODE  = 0,
   parameter int unsigned TERM_WORD  = DEFAULT_TERM_WORD,
   localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_rx_en,
   input  logic                  i_tx_busy,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_tx_en,
   output logic [LW-1:0]         o_level,
   output logic                  o_overflow,
   output logic [3:0]            o_led
`ifdef UART_ECHO_STATS_EN
   ,
   output logic [STATS_WIDTH-1:0] o_rx_count,
   output logic [STATS_WIDTH-1:0] o_drop_count
`endif
);

   localparam logic [DATA_WIDTH-1:0] TERM       = DATA_WIDTH'(TERM_WORD);
   localparam logic [LW-1:0]         FULL_LEVEL = LW'(FIFO_DEPTH);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_en_q, tx_en_d;
   logic [LW-1:0]         rel_q, rel_d;
   logic                  ovf_q, ovf_d;
   logic [3:0]            led_q, led_d;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [LW-1:0]         fifo_level;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  push;
   logic                  pop;
   logic [LW-1:0]         level_next;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push),
      .i_push_data (i_rx_data),
      .i_pop       (pop),
      .o_pop_data  (head_data),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_level     (fifo_level)
   );

   assign push = i_rx_en && !fifo_full;

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      tx_en_d   = 1'b0;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if ((rel_q != '0) && !fifo_empty && !i_tx_busy) begin
               pop       = 1'b1;
               tx_data_d = head_data;
               tx_en_d   = 1'b1;
               state_d   = WAIT_ACK;
            end
         end
         WAIT_ACK:  if (i_tx_busy)  state_d = WAIT_DONE;
         WAIT_DONE: if (!i_tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // In line mode the release count only grows when a terminator lands, or
   // when a full FIFO without one would otherwise stall forever.
   always_comb begin
      level_next = fifo_level;
      if (push && !pop) level_next = fifo_level + LW'(1);
      if (pop && !push) level_next = fifo_level - LW'(1);
      rel_d = rel_q;
      if (LINE_MODE == 0) begin
         rel_d = level_next;
      end else begin
         if (pop) rel_d = rel_q - LW'(1);
         if (push && (i_rx_data == TERM)) rel_d = level_next;
         if ((level_next == FULL_LEVEL) && (rel_d == '0)) rel_d = level_next;
      end
      ovf_d = ovf_q | (i_rx_en && fifo_full);
      led_d = push ? i_rx_data[3:0] : led_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         tx_data_q <= '0;
         tx_en_q   <= 1'b0;
         rel_q     <= '0;
         ovf_q     <= 1'b0;
         led_q     <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
         rel_q     <= rel_d;
         ovf_q     <= ovf_d;
         led_q     <= led_d;
      end
   end

   assign o_tx_data  = tx_data_q;
   assign o_tx_en    = tx_en_q;
   assign o_level    = fifo_level;
   assign o_overflow = ovf_q;
   assign o_led      = led_q;

`ifdef UART_ECHO_STATS_EN
   logic [STATS_WIDTH-1:0] rx_count_q, rx_count_d;
   logic [STATS_WIDTH-1:0] drop_count_q, drop_count_d;

   always_comb begin
      rx_count_d   = rx_count_q;
      drop_count_d = drop_count_q;
      if (push && (rx_count_q != '1)) rx_count_d = rx_count_q + STATS_WIDTH'(1);
      if (i_rx_en && fifo_full && (drop_count_q != '1))
         drop_count_d = drop_count_q + STATS_WIDTH'(1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         rx_count_q   <= rx_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign o_rx_count   = rx_count_q;
   assign o_drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: one echo-mode and one line-mode
// instance, each driven against a queue-based reference and a transmitter model.
module tb_uart_echo_fifo;

   localparam int          DEPTH = 16;
   localparam int          LW    = 5;
   localparam logic [7:0]  TERM  = 8'h0D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]    rx_data [2];
   logic          rx_en   [2];
   logic          tx_busy [2];
   logic [7:0]    tx_data0, tx_data1;
   logic          tx_en0, tx_en1;
   logic [LW-1:0] level0, level1;
   logic          ovf0, ovf1;
   logic [3:0]    led0, led1;
`ifdef UART_ECHO_STATS_EN
   logic [15:0]   rxc0, rxc1, drc0, drc1;
`endif

   uart_echo_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .LINE_MODE(0), .TERM_WORD(32'h0D)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data[0]), .i_rx_en(rx_en[0]),
      .i_tx_busy(tx_busy[0]), .o_tx_data(tx_data0), .o_tx_en(tx_en0),
      .o_level(level0), .o_overflow(ovf0), .o_led(led0)
`ifdef UART_ECHO_STATS_EN
      , .o_rx_count(rxc0), .o_drop_count(drc0)
`endif
   );

   uart_echo_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .LINE_MODE(1), .TERM_WORD(32'h0D)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data[1]), .i_rx_en(rx_en[1]),
      .i_tx_busy(tx_busy[1]), .o_tx_data(tx_data1), .o_tx_en(tx_en1),
      .o_level(level1), .o_overflow(ovf1), .o_led(led1)
`ifdef UART_ECHO_STATS_EN
      , .o_rx_count(rxc1), .o_drop_count(drc1)
`endif
   );

   // Reference state: a ring of expected words per instance plus release count.
   logic [7:0] mq [2][64];
   int         head [2];
   int         occ [2];
   int         rel [2];
   bit         m_ovf [2];
   logic [3:0] m_led [2];
   int         emitted [2];
   int         last_tx [2];
   int         pend [2];
   int         bcnt [2];
   bit         hold [2];
   int         m_rxc [2];
   int         m_drc [2];
   int         cyc;
   int         errors;
   int         checks;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic sample(input int d, output logic [7:0] td, output logic te,
                         output logic [LW-1:0] lv, output logic ov, output logic [3:0] ld);
      if (d == 0) begin
         td = tx_data0; te = tx_en0; lv = level0; ov = ovf0; ld = led0;
      end else begin
         td = tx_data1; te = tx_en1; lv = level1; ov = ovf1; ld = led1;
      end
   endtask

   task automatic resetModel();
      for (int d = 0; d < 2; d++) begin
         head[d] = 0; occ[d] = 0; rel[d] = 0; m_ovf[d] = 0; m_led[d] = '0;
         last_tx[d] = -100; pend[d] = 0; bcnt[d] = 0; hold[d] = 0;
         m_rxc[d] = 0; m_drc[d] = 0;
         rx_en[d] = 1'b0; rx_data[d] = '0; tx_busy[d] = 1'b0;
      end
   endtask

   // One clock: decide acceptance on pre-edge occupancy, then check post-edge outputs.
   task automatic step();
      bit acc [2];
      bit drp [2];
      logic [7:0]    td;
      logic          te;
      logic [LW-1:0] lv;
      logic          ov;
      logic [3:0]    ld;
      for (int d = 0; d < 2; d++) begin
         acc[d] = rx_en[d] && (occ[d] < DEPTH);
         drp[d] = rx_en[d] && !(occ[d] < DEPTH);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         sample(d, td, te, lv, ov, ld);
         if (te) begin
            checkOutput("tx_release", 32'(rel[d] > 0), 1);
            checkOutput("tx_nonempty", 32'(occ[d] > 0), 1);
            checkOutput("tx_data", 32'(td), 32'(mq[d][head[d]]));
            checkOutput("tx_spacing", 32'((cyc - last_tx[d]) >= 4), 1);
            last_tx[d] = cyc;
            emitted[d]++;
            if (occ[d] > 0) begin
               head[d] = (head[d] + 1) % 64;
               occ[d]--;
            end
            if (rel[d] > 0) rel[d]--;
         end
         if (acc[d]) begin
            mq[d][(head[d] + occ[d]) % 64] = rx_data[d];
            occ[d]++;
            m_led[d] = rx_data[d][3:0];
            if (m_rxc[d] < 16'hFFFF) m_rxc[d]++;
            if (d == 1 && rx_data[d] == TERM) rel[d] = occ[d];
         end
         if (drp[d]) begin
            m_ovf[d] = 1;
            if (m_drc[d] < 16'hFFFF) m_drc[d]++;
         end
         if (d == 0) rel[d] = occ[d];
         else if (occ[d] == DEPTH && rel[d] == 0) rel[d] = occ[d];
         checkOutput("level", 32'(lv), 32'(occ[d]));
         checkOutput("overflow", 32'(ov), 32'(m_ovf[d]));
         checkOutput("led", 32'(ld), 32'(m_led[d]));
`ifdef UART_ECHO_STATS_EN
         checkOutput("rx_count", 32'(d == 0 ? rxc0 : rxc1), 32'(m_rxc[d]));
         checkOutput("drop_count", 32'(d == 0 ? drc0 : drc1), 32'(m_drc[d]));
`endif
         if (bcnt[d] > 0) bcnt[d]--;
         if (pend[d] != 0) begin
            bcnt[d] = int'($urandom_range(1, 3));
            pend[d] = 0;
         end
         if (te) pend[d] = 1;
         tx_busy[d] = hold[d] || (bcnt[d] > 0);
      end
   endtask

   task automatic applyStimulus(input int d, input logic [7:0] data);
      rx_en[d]   = 1'b1;
      rx_data[d] = data;
      step();
      rx_en[d]   = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((rel[0] > 0 || rel[1] > 0 || pend[0] != 0 || pend[1] != 0 ||
              bcnt[0] > 0 || bcnt[1] > 0) && n < budget) begin
         step();
         n++;
      end
      checkOutput("drain_timeout", 32'(n < budget), 1);
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_tx_data0"}, 32'(tx_data0), 0);
      checkOutput({tag, "_tx_en0"}, 32'(tx_en0), 0);
      checkOutput({tag, "_level0"}, 32'(level0), 0);
      checkOutput({tag, "_ovf0"}, 32'(ovf0), 0);
      checkOutput({tag, "_led0"}, 32'(led0), 0);
      checkOutput({tag, "_level1"}, 32'(level1), 0);
      checkOutput({tag, "_ovf1"}, 32'(ovf1), 0);
   endtask

   initial begin
      int base;
      logic [7:0] v;
      errors = 0; checks = 0; cyc = 0;
      emitted[0] = 0; emitted[1] = 0;
      resetModel();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;

      // Echo mode: single word appears two cycles after the receive strobe.
      applyStimulus(0, 8'h41);
      checkOutput("first_tx_early", 32'(tx_en0), 0);
      step();
      checkOutput("first_tx_en", 32'(tx_en0), 1);
      checkOutput("first_tx_data", 32'(tx_data0), 32'h41);
      checkOutput("first_led", 32'(led0), 32'h1);
      drain(200);

      // Busy held: 17 words into a 16-deep FIFO, last one dropped.
      hold[0] = 1; tx_busy[0] = 1'b1;
      base = emitted[0];
      for (int i = 0; i < 17; i++) applyStimulus(0, 8'(i));
      checkOutput("full_level", 32'(level0), 16);
      checkOutput("full_overflow", 32'(ovf0), 1);
      hold[0] = 0; tx_busy[0] = 1'b0;
      drain(500);
      checkOutput("full_echoed", 32'(emitted[0] - base), 16);

      // Line mode: nothing leaves until the terminator arrives.
      base = emitted[1];
      applyStimulus(1, 8'h61);
      applyStimulus(1, 8'h62);
      repeat (8) step();
      checkOutput("line_held", 32'(emitted[1] - base), 0);
      checkOutput("line_level", 32'(level1), 2);
      applyStimulus(1, TERM);
      drain(200);
      checkOutput("line_echoed", 32'(emitted[1] - base), 3);

      // Line mode flush: a full FIFO without terminator still drains.
      base = emitted[1];
      for (int i = 0; i < 16; i++) begin
         v = 8'($urandom_range(0, 255));
         if (v == TERM) v = 8'h0E;
         applyStimulus(1, v);
      end
      drain(500);
      checkOutput("flush_echoed", 32'(emitted[1] - base), 16);
      checkOutput("flush_level", 32'(level1), 0);

      // Randomized traffic on both instances with occasional stalls.
      for (int c = 0; c < 600; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (c % 40 == 0) hold[d] = ($urandom_range(0, 5) == 0);
            tx_busy[d] = hold[d] || (bcnt[d] > 0);
            rx_en[d]   = ($urandom_range(0, 3) == 0);
            rx_data[d] = 8'($urandom_range(0, 255));
            if (d == 1 && $urandom_range(0, 5) == 0) rx_data[d] = TERM;
         end
         step();
      end
      for (int d = 0; d < 2; d++) begin
         rx_en[d] = 1'b0; hold[d] = 0;
      end
      drain(2000);
      applyStimulus(1, TERM);
      drain(500);
      checkOutput("random_level0", 32'(level0), 0);
      checkOutput("random_level1", 32'(level1), 0);

      // Simultaneous push and pop at occupancy 3, then reset during WAIT_DONE.
      hold[0] = 1; tx_busy[0] = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(0, 8'h20 + 8'(i));
      checkOutput("pp_level_before", 32'(level0), 3);
      hold[0] = 0; tx_busy[0] = 1'b0;
      applyStimulus(0, 8'h55);
      checkOutput("pp_level", 32'(level0), 3);
      checkOutput("pp_tx_en", 32'(tx_en0), 1);
      hold[0] = 1;
      step();
      step();
      rst = 1'b1;
      #1;
      checkResetOutputs("midrst");
      @(posedge clk);
      #1;
      resetModel();
      rst = 1'b0;
      applyStimulus(0, 8'h37);
      step();
      checkOutput("post_rst_tx_data", 32'(tx_data0), 32'h37);
      drain(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Buffered, parametrised echo engine sitting between a `uart_rx` and a `uart_tx` instance in FPGA loopback and bring-up designs. Received words are queued in an internal FIFO and replayed to the transmitter under a busy-aware handshake, so back-to-back receive traffic is never lost while the transmitter is occupied. An optional line mode holds data until a terminator word arrives, and a status nibble drives board LEDs.

## Interface
- `DATA_WIDTH`, 8: width of one UART word.
- `FIFO_DEPTH`, 16: entries; power of two, ≥ 2.
- `LINE_MODE`, 0: 0 = echo each word as available; 1 = release only complete lines.
- `TERM_WORD`, 8'h0D: line terminator compared in line mode; zero-extended or truncated to `DATA_WIDTH`.
- `i_clk` input 1: system clock.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_rx_data` input `DATA_WIDTH`: received word; valid when `i_rx_en`.
- `i_rx_en` input 1: single-cycle receive strobe.
- `i_tx_busy` input 1: transmitter busy.
- `o_tx_data` output `DATA_WIDTH`: word to transmit; held between launches.
- `o_tx_en` output 1: single-cycle transmit strobe.
- `o_level` output `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `o_overflow` output 1: sticky; set on any dropped word.
- `o_led` output 4: bits [3:0] of last accepted received word.

## Operation
- Reset values: `o_tx_data`=0, `o_tx_en`=0, `o_level`=0, `o_overflow`=0, `o_led`=0, FSM in IDLE, release count 0.
- Write: `i_rx_en` with occupancy < `FIFO_DEPTH` (sampled before any same-cycle pop) stores the word and updates `o_led`. When full, word is dropped, `o_overflow` set, `o_led` unchanged.
- Simultaneous push and pop are both performed; occupancy unchanged.
- Release count: in `LINE_MODE`=0 equals occupancy. In `LINE_MODE`=1, incremented to occupancy when a `TERM_WORD` is written (count covers every word through the terminator); decremented on each pop. If the FIFO becomes full with no terminator queued, release count is forced to occupancy (flush), preventing deadlock.
- TX FSM:
  - IDLE: if release count > 0 and `i_tx_busy`=0, pop head to `o_tx_data`, pulse `o_tx_en`, go WAIT_ACK.
  - WAIT_ACK: on `i_tx_busy`=1 go WAIT_DONE.
  - WAIT_DONE: on `i_tx_busy`=0 go IDLE.
- The attached transmitter raises `i_tx_busy` in the cycle following `o_tx_en`; no timeout is provided.
- Pointers wrap modulo `FIFO_DEPTH`; occupancy uses one extra bit to distinguish full from empty.
- `o_overflow` clears only on reset.

## Timing
- `i_rx_en` in cycle N → word in FIFO after edge N+1; earliest `o_tx_en` in cycle N+2 (FSM IDLE, transmitter idle).
- `o_tx_en` and new `o_tx_data` are registered and change on the same edge; `o_tx_en` high exactly one cycle.
- Minimum spacing between consecutive `o_tx_en` pulses: 4 cycles (launch, ack, done, idle).
- `o_level` reflects pushes/pops one cycle after the strobe edge.
- Asserting `i_rst` mid-frame: all state returns to reset values immediately; queued words are discarded, in-flight transmitter frame is not aborted by this block.

## Configuration
- `UART_ECHO_STATS_EN`: when defined, adds outputs `o_rx_count` (16 bits, accepted words) and `o_drop_count` (16 bits, dropped words), both saturating at 16'hFFFF, reset 0. When undefined, these ports and counters are absent; all other behaviour identical.

## Structure
- Package `uart_echo_pkg`: TX FSM state enum (IDLE, WAIT_ACK, WAIT_DONE), default `TERM_WORD` constant, stats counter width constant.
- Sub-module `sync_fifo` (parametrised `DATA_WIDTH`, `FIFO_DEPTH`; push/pop/full/empty/level); line-mode release logic and FSM stay in the top.

## Test plan
- `LINE_MODE`=0, idle transmitter, push 8'h41 → `o_tx_en` 2 cycles later with `o_tx_data`=8'h41, `o_led`=4'h1.
- Hold `i_tx_busy`=1, push 17 words 0x00..0x10 with depth 16 → `o_level`=16, `o_overflow`=1, 0x10 dropped; release busy → 0x00..0x0F echoed in order.
- `LINE_MODE`=1, push "ab" → no `o_tx_en`; push 8'h0D → 8'h61, 8'h62, 8'h0D echoed in order.
- `LINE_MODE`=1, push 16 non-terminator words → flush: all 16 echoed.
- Push and pop in same cycle at occupancy 3 → `o_level` stays 3; assert `i_rst` while WAIT_DONE → all outputs 0, FSM IDLE, `o_level`=0.
- With `UART_ECHO_STATS_EN`, 20 pushes into full FIFO → `o_drop_count`=20, `o_rx_count` unchanged.
